// File: rtl/intdiv_pkg.sv
// Shared types and constants for the intdiv issue/retire controller.
// Entry widths are fixed here; the top-level N and TW must match them.
package intdiv_pkg;

    localparam int unsigned INTDIV_N          = 32;
    localparam int unsigned INTDIV_TW         = 4;
    localparam int unsigned INTDIV_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        SPEC
    } state_t;

    typedef struct packed {
        logic [INTDIV_N-1:0]  z;
        logic [INTDIV_N-1:0]  r;
        logic [INTDIV_TW-1:0] tag;
        logic                 dz;
        logic                 ovf;
    } result_t;

    function automatic logic [INTDIV_N-1:0] min_int(input int unsigned n);
        logic [INTDIV_N-1:0] v;
        for (int i = 0; i < INTDIV_N; i++) begin
            v[i] = (i == int'(n) - 1);
        end
        return v;
    endfunction

    function automatic logic [INTDIV_N-1:0] all_ones(input int unsigned n);
        logic [INTDIV_N-1:0] v;
        for (int i = 0; i < INTDIV_N; i++) begin
            v[i] = (i < int'(n));
        end
        return v;
    endfunction

endpackage

// File: rtl/intdiv_issue_if.sv
// Operand-in / result-out handshake bundle of the intdiv issue controller.
interface intdiv_issue_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned TW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x;
    logic [N-1:0]  in_y;
    logic [TW-1:0] in_tag;

    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_z;
    logic [N-1:0]  out_r;
    logic [TW-1:0] out_tag;
    logic          out_dz;
    logic          out_ovf;

    modport slave (
        input  in_valid, in_x, in_y, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_r, out_tag, out_dz, out_ovf
    );

    modport master (
        output in_valid, in_x, in_y, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_r, out_tag, out_dz, out_ovf
    );
endinterface

// File: rtl/intdiv_result_fifo.sv
// Two-entry result FIFO built from a head and a tail register; the head
// register drives the outputs directly.
module intdiv_result_fifo
    import intdiv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  result_t     i_data,
    input  logic        i_pop,
    output logic        o_valid,
    output result_t     o_head,
    output logic [1:0]  o_count
);

    result_t    r_head;
    result_t    r_tail;
    logic [1:0] r_count;

    result_t    w_head_d;
    result_t    w_tail_d;
    logic [1:0] w_count_d;
    logic       w_push;
    logic       w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count < 2'(INTDIV_FIFO_DEPTH)) || w_pop);

    always_comb begin
        w_head_d  = r_head;
        w_tail_d  = r_tail;
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_head_d = i_data;
                end else begin
                    w_tail_d = i_data;
                end
                w_count_d = r_count + 2'd1;
            end
            2'b01: begin
                w_head_d  = r_tail;
                w_count_d = r_count - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new entry lands behind whatever remains.
                if (r_count == 2'd1) begin
                    w_head_d = i_data;
                end else begin
                    w_head_d = r_tail;
                    w_tail_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            r_head  <= w_head_d;
            r_tail  <= w_tail_d;
            r_count <= w_count_d;
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/intdiv_issue.sv
// Issue/retire controller for the combinational signed divider array: holds
// operands for LAT cycles, then queues quotient/remainder in a result FIFO.
module intdiv_issue
    import intdiv_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned LAT = 4,
    parameter int unsigned TW  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    intdiv_issue_if.slave  bus,
    output logic [N-1:0]   o_arr_x,
    output logic [N-1:0]   o_arr_y,
    input  logic [N-1:0]   i_arr_z,
    input  logic [N-1:0]   i_arr_r,
    output logic           o_busy
);

    localparam int unsigned CW = $clog2(LAT + 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_arr_x;
    logic [N-1:0]  r_arr_y;
    logic [N-1:0]  r_spec_x;
    logic [TW-1:0] r_tag;
    logic          r_dz;
    logic          r_ovf;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_in_dz;
    logic          w_in_ovf;
    logic          w_push;
    result_t       w_push_data;
    result_t       w_head;
    logic          w_head_valid;
    logic [1:0]    w_count;

    assign w_in_ready = !i_rst && (r_state == IDLE) && (w_count < 2'(INTDIV_FIFO_DEPTH));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_in_dz    = (bus.in_y == '0);
    assign w_in_ovf   = (bus.in_x == min_int(N)) && (bus.in_y == all_ones(N));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_in_dz || w_in_ovf) begin
                        w_state_nxt = SPEC;
                    end else begin
                        w_state_nxt = EVAL;
                        w_cnt_nxt   = CW'(LAT - 1);
                    end
                end
            end
            EVAL: begin
                if (r_cnt == '0) begin
                    w_push          = 1'b1;
                    w_push_data.z   = i_arr_z;
                    w_push_data.r   = i_arr_r;
                    w_push_data.tag = r_tag;
                    w_state_nxt     = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            SPEC: begin
                w_push          = 1'b1;
                w_push_data.tag = r_tag;
                w_push_data.dz  = r_dz;
                w_push_data.ovf = r_ovf;
                if (r_dz) begin
                    w_push_data.z = all_ones(N);
                    w_push_data.r = r_spec_x;
                end else begin
                    w_push_data.z = min_int(N);
                    w_push_data.r = '0;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_arr_x  <= '0;
            r_arr_y  <= '0;
            r_spec_x <= '0;
            r_tag    <= '0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_spec_x <= bus.in_x;
                r_tag    <= bus.in_tag;
                r_dz     <= w_in_dz;
                r_ovf    <= w_in_ovf;
                // Special cases bypass the array, so its inputs keep the last real operands.
                if (!(w_in_dz || w_in_ovf)) begin
                    r_arr_x <= bus.in_x;
                    r_arr_y <= bus.in_y;
                end
            end
        end
    end

    intdiv_result_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (bus.out_ready),
        .o_valid (w_head_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_head_valid;
    assign bus.out_z     = w_head.z;
    assign bus.out_r     = w_head.r;
    assign bus.out_tag   = w_head.tag;
    assign bus.out_dz    = w_head.dz;
    assign bus.out_ovf   = w_head.ovf;
    assign o_arr_x       = r_arr_x;
    assign o_arr_y       = r_arr_y;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_intdiv_issue.sv
// Self-checking bench for intdiv_issue with a behavioural model of the divider array.
module tb_intdiv_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] arr_x, arr_y, arr_z, arr_r;
    logic        busy;

    always #5 clk = ~clk;

    intdiv_issue_if #(.N(32), .TW(4)) bus ();

    intdiv_issue #(.N(32), .LAT(4), .TW(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus),
        .o_arr_x (arr_x),
        .o_arr_y (arr_y),
        .i_arr_z (arr_z),
        .i_arr_r (arr_r),
        .o_busy  (busy)
    );

    // Divider array: signed, truncating; guarded so illegal operands never trap the simulator.
    always_comb begin
        if (arr_y == 32'd0) begin
            arr_z = 32'hFFFF_FFFF;
            arr_r = arr_x;
        end else if (arr_x == 32'h8000_0000 && arr_y == 32'hFFFF_FFFF) begin
            arr_z = arr_x;
            arr_r = 32'd0;
        end else begin
            arr_z = $signed(arr_x) / $signed(arr_y);
            arr_r = $signed(arr_x) % $signed(arr_y);
        end
    end

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  tag;
        logic [31:0] ez;
        logic [31:0] er;
        logic        edz;
        logic        eovf;
        int          lat;
    } vec_t;

    vec_t vecs[11];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " in_ready wait"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle wait"}, 32'(busy), 32'd0);
    endtask

    // Starts at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag);
        wait_ready("issue");
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_ax, exp_ay;
        int          cyc;
        logic        stale;

        vecs[0]  = '{32'd7,         32'd3,         4'h1, 32'd2,         32'd1,         1'b0, 1'b0, 5};
        vecs[1]  = '{32'hFFFF_FFF9, 32'd3,         4'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 5};
        vecs[2]  = '{32'h1234_5678, 32'd0,         4'h3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 2};
        vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 4'h4, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 2};
        vecs[4]  = '{32'd7,         32'hFFFF_FFFD, 4'h5, 32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0, 5};
        vecs[5]  = '{32'd100,       32'd7,         4'h6, 32'd14,        32'd2,         1'b0, 1'b0, 5};
        vecs[6]  = '{32'h8000_0000, 32'd1,         4'h7, 32'h8000_0000, 32'd0,         1'b0, 1'b0, 5};
        vecs[7]  = '{32'd0,         32'd5,         4'h8, 32'd0,         32'd0,         1'b0, 1'b0, 5};
        vecs[8]  = '{32'hFFFF_FFFF, 32'd0,         4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[9]  = '{32'h8000_0000, 32'd2,         4'hA, 32'hC000_0000, 32'd0,         1'b0, 1'b0, 5};
        vecs[10] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 4'hB, 32'd2,         32'hFFFF_FFFE, 1'b0, 1'b0, 5};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst arr_x", arr_x, 32'd0);
        chk("rst arr_y", arr_y, 32'd0);
        chk("rst out_z", bus.out_z, 32'd0);
        chk("rst out_r", bus.out_r, 32'd0);
        chk("rst out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst out_dz", 32'(bus.out_dz), 32'd0);
        chk("rst out_ovf", 32'(bus.out_ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        exp_ax = 32'd0;
        exp_ay = 32'd0;
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].x, vecs[i].y, vecs[i].tag);
            chk($sformatf("v%0d busy c1", i), 32'(busy), 32'd1);
            chk($sformatf("v%0d in_ready c1", i), 32'(bus.in_ready), 32'd0);
            cyc = 1;
            while (!bus.out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].lat));
            chk($sformatf("v%0d z", i), bus.out_z, vecs[i].ez);
            chk($sformatf("v%0d r", i), bus.out_r, vecs[i].er);
            chk($sformatf("v%0d tag", i), 32'(bus.out_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d dz", i), 32'(bus.out_dz), 32'(vecs[i].edz));
            chk($sformatf("v%0d ovf", i), 32'(bus.out_ovf), 32'(vecs[i].eovf));
            if (!vecs[i].edz && !vecs[i].eovf) begin
                exp_ax = vecs[i].x;
                exp_ay = vecs[i].y;
            end
            chk($sformatf("v%0d arr_x", i), arr_x, exp_ax);
            chk($sformatf("v%0d arr_y", i), arr_y, exp_ay);
            @(negedge clk);
            chk($sformatf("v%0d popped", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: two results fill the FIFO, a third waits for a pop.
        bus.out_ready = 1'b0;
        issue(32'd100, 32'd7, 4'hC);
        wait_idle("bp A");
        issue(32'd7, 32'd3, 4'hD);
        wait_idle("bp B");
        bus.in_valid = 1'b1;
        bus.in_x     = 32'hFFFF_FFF9;
        bus.in_y     = 32'd3;
        bus.in_tag   = 4'hE;
        repeat (3) begin
            @(negedge clk);
            chk("bp full in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("bp head A z", bus.out_z, 32'd14);
        chk("bp head A tag", 32'(bus.out_tag), 32'hC);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp pop in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp head B z", bus.out_z, 32'd2);
        chk("bp head B tag", 32'(bus.out_tag), 32'hD);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp C busy", 32'(busy), 32'd1);
        wait_idle("bp C");
        bus.out_ready = 1'b1;
        chk("bp drain B tag", 32'(bus.out_tag), 32'hD);
        chk("bp drain B r", bus.out_r, 32'd1);
        @(negedge clk);
        chk("bp drain C valid", 32'(bus.out_valid), 32'd1);
        chk("bp drain C tag", 32'(bus.out_tag), 32'hE);
        chk("bp drain C z", bus.out_z, 32'hFFFF_FFFE);
        chk("bp drain C r", bus.out_r, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("bp drained", 32'(bus.out_valid), 32'd0);

        // Reset in cycle 2 of EVAL with one result already queued.
        bus.out_ready = 1'b0;
        issue(32'd7, 32'd3, 4'h1);
        wait_idle("rst q");
        chk("rst q valid", 32'(bus.out_valid), 32'd1);
        issue(32'd100, 32'd7, 4'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid-rst in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after-rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("after-rst busy", 32'(busy), 32'd0);
        chk("after-rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("after-rst arr_x", arr_x, 32'd0);
        bus.out_ready = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no stale result", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intdiv_issue.md
# intdiv_issue

Sequential issue/retire controller wrapped around the combinational signed divider array `intdiv_intdiv`. It accepts operand pairs over a valid/ready handshake and registers them onto the array inputs. It holds those inputs stable for a programmable multicycle window, then captures quotient and remainder into a 2-entry result FIFO. Divide-by-zero and signed overflow bypass the array with fixed results.

## Interface
- `N`, 32, operand/result width; must match the array instance.
- `LAT`, 4, cycles the array inputs are held before the result is sampled; ≥1.
- `TW`, 4, width of the pass-through tag.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  operand pair accepted when `in_valid && in_ready` at a rising edge.
- `in_x`  in  N  dividend, two's complement.
- `in_y`  in  N  divisor, two's complement.
- `in_tag`  in  TW  opaque tag, returned with the result.
- `arr_x`  out  N  registered dividend to the array.
- `arr_y`  out  N  registered divisor to the array.
- `arr_z`  in  N  array quotient.
- `arr_r`  in  N  array remainder.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops the head when `out_valid && out_ready`.
- `out_z`  out  N  quotient.
- `out_r`  out  N  remainder.
- `out_tag`  out  TW  tag.
- `out_dz`  out  1  divide-by-zero flag.
- `out_ovf`  out  1  overflow flag.
- `busy`  out  1  operation in flight; high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready = !rst && count<2`. On accept: register x, y, tag and the special-case flags. Next state is SPEC if a special case applies, else EVAL with `cnt = LAT-1`.
  - EVAL: decrement `cnt`. When `cnt==0`, push `{arr_z, arr_r, tag, 0, 0}` into the FIFO and return to IDLE.
  - SPEC: push the fixed result and return to IDLE.
- Divide-by-zero: `y == 0`. Result is `z = {N{1}}`, `r = x`, `dz = 1`.
- Overflow: `x == 1<<(N-1)` and `y == {N{1}}`. Result is `z = x`, `r = 0`, `ovf = 1`. The two special cases are mutually exclusive.
- Normal path: `arr_z` and `arr_r` are forwarded unmodified, using the array's signed, truncating convention.
- `arr_x` and `arr_y` change only on accept and otherwise hold their last value, including through SPEC and IDLE.
- Only one operation is in flight at a time. FIFO occupancy can only fall while busy, so a push never finds the FIFO full.
- FIFO:
  - 2 entries; outputs driven from the head register.
  - Push and pop in the same cycle are allowed, and the count is unchanged.
  - A pop on an empty FIFO is ignored.
- Reset asserted in any cycle:
  - next state is IDLE;
  - FIFO is flushed;
  - the in-flight operation is discarded and produces no output.

## Timing
- Reset values:
  - `out_valid=0`, `busy=0`;
  - `arr_x=0`, `arr_y=0`;
  - `out_z=0`, `out_r=0`, `out_tag=0`, `out_dz=0`, `out_ovf=0`;
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after reset.
- Normal path:
  - Accept in cycle 0; `arr_x`/`arr_y` are valid from cycle 1.
  - The result is sampled at the end of cycle LAT.
  - `out_valid` rises in cycle LAT+1 if the FIFO was empty.
  - `in_ready` is low in cycles 1..LAT.
- Special path: push at the end of cycle 1; `out_valid` is high in cycle 2; `in_ready` is high again in cycle 2.
- Maximum throughput is one operation per LAT+1 cycles (normal) or per 2 cycles (special).
- Array paths are constrained as LAT-cycle multicycle paths from `arr_x`/`arr_y` to the FIFO capture.

## Structure
- Shared package `intdiv_pkg` holds:
  - the state enum `{IDLE, EVAL, SPEC}`;
  - the result-entry struct (z, r, tag, dz, ovf);
  - `INTDIV_FIFO_DEPTH = 2`;
  - helper functions for the MIN_INT and all-ones constants of width N.
- Sub-module `intdiv_result_fifo`: 2-entry synchronous FIFO with the same clock and reset.
- Counter width is `$clog2(LAT+1)`.

## Test plan
- `x=7`, `y=3`, LAT=4, `out_ready=1` -> `z=2`, `r=1`, `out_valid` in cycle 5, flags 0, tag echoed.
- `x=0xFFFFFFF9` (−7), `y=3` -> `z=0xFFFFFFFE`, `r=0xFFFFFFFF`.
- `x=0x12345678`, `y=0` -> cycle 2: `z=0xFFFFFFFF`, `r=0x12345678`, `dz=1`; `arr_x`/`arr_y` remain at the previous values.
- `x=0x80000000`, `y=0xFFFFFFFF` -> `z=0x80000000`, `r=0`, `ovf=1`, in cycle 2.
- `out_ready=0`, issue three divisions back-to-back:
  - the first two fill the FIFO;
  - `in_ready` stays 0 after the second completes;
  - one pop raises `in_ready` in the same cycle;
  - results exit in issue order with the correct tags.
- `rst` pulsed in cycle 2 of EVAL with one entry already queued -> `out_valid=0` next cycle, no stale result ever appears, `in_ready=1` after reset.
